// File: rtl/cycle_sequencer.sv
// cycle_sequencer: one-hot T-state ring and M-cycle shift register that every
// microcode block decodes, with instruction-boundary HALT entry and exit.
// Optional build macro CYCLE_SEQUENCER_SINGLE_STEP_EN adds a debug hold that
// parks the sequencer at M1/T1 and releases one instruction per i_Dbg_Step.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// RUN     | normal execution; count advances on each unstalled T4
// HALT    | waiting for i_Wake; count parked at M1, step ring keeps turning
// DBG     | (debug build only) parked at M1/T1 until i_Dbg_Step or hold drops
module cycle_sequencer #(
    parameter int N_TSTATE = 4,
    parameter int N_MCYCLE = 8
) (
    input  logic                i_Clk,
    input  logic                i_Reset_n,
    input  logic                i_IR_Fetch,
    input  logic                i_Stall,
    input  logic                i_Halt_Req,
    input  logic                i_Wake,
`ifdef CYCLE_SEQUENCER_SINGLE_STEP_EN
    input  logic                i_Dbg_Hold,
    input  logic                i_Dbg_Step,
`endif
    output logic [N_TSTATE-1:0] o_Cycle_Step,
    output logic [N_MCYCLE-1:0] o_Cycle_Count,
    output logic                o_Instr_Start,
    output logic                o_Boundary,
    output logic                o_Halted,
    output logic                o_Overrun
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
`ifdef CYCLE_SEQUENCER_SINGLE_STEP_EN
    localparam logic [1:0] ST_DBG  = 2'd2;
`endif

    localparam logic [N_TSTATE-1:0] T1 = {{(N_TSTATE-1){1'b0}}, 1'b1};
    localparam logic [N_MCYCLE-1:0] M1 = {{(N_MCYCLE-1){1'b0}}, 1'b1};

    logic [N_TSTATE-1:0] step_q, step_d;
    logic [N_MCYCLE-1:0] count_q, count_d;
    logic [1:0]          state_q, state_d;
    logic                overrun_q, overrun_d;
    logic                t4_go;
    logic                halted;

    // The count only ever moves on the edge that leaves an unstalled T4.
    assign t4_go  = step_q[N_TSTATE-1] & ~i_Stall;
    assign halted = (state_q != ST_RUN);

    // Next-state logic for the step ring, count register and RUN/HALT FSM.
    always_comb begin
        step_d    = step_q;
        count_d   = count_q;
        state_d   = state_q;
        overrun_d = overrun_q;

        if (!i_Stall) begin
            step_d = {step_q[N_TSTATE-2:0], step_q[N_TSTATE-1]};
        end

        case (state_q)
            ST_RUN: begin
                if (t4_go) begin
                    if (i_IR_Fetch) begin
                        count_d = M1;
`ifdef CYCLE_SEQUENCER_SINGLE_STEP_EN
                        if (i_Dbg_Hold) begin
                            state_d = ST_DBG;
                        end else
`endif
                        // A pending interrupt at the boundary cancels HALT entry.
                        if (i_Halt_Req && !i_Wake) begin
                            state_d = ST_HALT;
                        end
                    end else if (count_q[N_MCYCLE-1]) begin
                        count_d   = M1;
                        overrun_d = 1'b1;
                    end else begin
                        count_d = count_q << 1;
                    end
                end
            end
            ST_HALT: begin
                count_d = M1;
                // Leaving at T4 means the ring wraps to T1 as RUN resumes.
                if (t4_go && i_Wake) begin
                    state_d = ST_RUN;
                end
            end
`ifdef CYCLE_SEQUENCER_SINGLE_STEP_EN
            ST_DBG: begin
                step_d  = T1;
                count_d = M1;
                if (i_Dbg_Step || !i_Dbg_Hold) begin
                    state_d = ST_RUN;
                end
            end
`endif
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers; reset lands directly on M1/T1 in RUN.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            step_q    <= T1;
            count_q   <= M1;
            state_q   <= ST_RUN;
            overrun_q <= 1'b0;
        end else begin
            step_q    <= step_d;
            count_q   <= count_d;
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_Cycle_Step  = step_q;
    assign o_Cycle_Count = count_q;
    assign o_Halted      = halted;
    assign o_Overrun     = overrun_q;
    assign o_Instr_Start = step_q[0] & count_q[0] & ~halted;
    assign o_Boundary    = step_q[N_TSTATE-1] & i_IR_Fetch & ~i_Stall & ~halted;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: a table of directed vectors plus
// hand-written multi-cycle sequences, checked through an expected-value queue.
module tb_cycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ir_fetch = 1'b0, stall = 1'b0, halt_req = 1'b0, wake = 1'b0;
    logic [3:0] step;
    logic [7:0] count;
    logic       instr_start, boundary, halted, overrun;

    cycle_sequencer #(.N_TSTATE(4), .N_MCYCLE(8)) dut (
        .i_Clk        (clk),
        .i_Reset_n    (rst_n),
        .i_IR_Fetch   (ir_fetch),
        .i_Stall      (stall),
        .i_Halt_Req   (halt_req),
        .i_Wake       (wake),
`ifdef CYCLE_SEQUENCER_SINGLE_STEP_EN
        .i_Dbg_Hold   (1'b0),
        .i_Dbg_Step   (1'b0),
`endif
        .o_Cycle_Step (step),
        .o_Cycle_Count(count),
        .o_Instr_Start(instr_start),
        .o_Boundary   (boundary),
        .o_Halted     (halted),
        .o_Overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         f, s, h, w;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          seen_m2 = 0;

    // Reference model: T-state and M-cycle held as plain indices.
    int mt = 0, mm = 0;
    bit mh = 0, mo = 0;

    function automatic logic [15:0] pack(logic [3:0] st, logic [7:0] ct,
                                         bit a, bit b, bit c, bit d);
        return {st, ct, a, b, c, d};
    endfunction

    function automatic logic [15:0] model_out(bit f, bit s);
        logic [3:0] st;
        logic [7:0] ct;
        st = 4'b0001 << mt;
        ct = 8'h01 << mm;
        return pack(st, ct, (mt == 0 && mm == 0 && !mh),
                    (mt == 3 && f && !s && !mh), mh, mo);
    endfunction

    task automatic model_step(bit f, bit s, bit h, bit w);
        if (!s) begin
            if (mt == 3) begin
                if (mh) begin
                    if (w) mh = 0;
                end else if (f) begin
                    mm = 0;
                    if (h && !w) mh = 1;
                end else if (mm == 7) begin
                    mm = 0;
                    mo = 1;
                end else begin
                    mm = mm + 1;
                end
            end
            mt = (mt + 1) % 4;
        end
    endtask

    task automatic model_reset();
        mt = 0; mm = 0; mh = 0; mo = 0;
    endtask

    function automatic logic [15:0] dut_out();
        return {step, count, instr_start, boundary, halted, overrun};
    endfunction

    task automatic compare(string tag, logic [15:0] act, logic [15:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (step|count|start|bnd|halt|ovr)",
                     tag, act, want);
        end
    endtask

    // Called at a falling edge: drive one clock of inputs, check, wait next fall.
    task automatic apply(string tag, bit f, bit s, bit h, bit w,
                         bit use_tbl, logic [15:0] texp);
        ir_fetch = f; stall = s; halt_req = h; wake = w;
        exp_q.push_back(use_tbl ? texp : model_out(f, s));
        model_step(f, s, h, w);
        #1;
        if (count == 8'h02) seen_m2++;
        compare(tag, dut_out(), exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic run(string tag, bit f, bit s, bit h, bit w);
        apply(tag, f, s, h, w, 1'b0, 16'h0);
    endtask

    task automatic run_to(string tag, int t, int m);
        for (int i = 0; i < 64 && !(mt == t && mm == m); i++) run(tag, 0, 0, 0, 0);
        if (!(mt == t && mm == m)) begin
            n_vec++; n_err++;
            $display("FAIL %s: position not reached, got T%0d M%0d", tag, mt + 1, mm + 1);
        end
    endtask

    task automatic finish_instr(string tag, bit h, bit w);
        for (int i = 0; i < 4 && mt != 3; i++) run(tag, 0, 0, 0, 0);
        run(tag, 1, 0, h, w);
    endtask

    task automatic async_reset(string tag);
        rst_n = 1'b0;
        #1;
        compare(tag, dut_out(), pack(4'b0001, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset release with IR fetch tied high: four T-states, always M1.
        for (int k = 0; k < 8; k++)
            tbl.push_back('{1, 0, 0, 0, pack(4'b0001 << (k % 4), 8'h01,
                            (k % 4) == 0, (k % 4) == 3, 0, 0)});
        // Fetch only during M3: M1, M2, M3, then back to M1.
        for (int m = 0; m < 3; m++)
            for (int t = 0; t < 4; t++)
                tbl.push_back('{(m == 2), 0, 0, 0, pack(4'b0001 << t, 8'h01 << m,
                                (t == 0 && m == 0), (t == 3 && m == 2), 0, 0)});
        tbl.push_back('{0, 0, 0, 0, pack(4'b0001, 8'h01, 1, 0, 0, 0)});

        ir_fetch = 0; stall = 0; halt_req = 0; wake = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        compare("reset_values", dut_out(), pack(4'b0001, 8'h01, 1, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            apply("table", tbl[i].f, tbl[i].s, tbl[i].h, tbl[i].w, 1'b1, tbl[i].exp);

        // Three stall clocks at M2/T2 stretch M2 to seven clocks.
        run_to("to_m2", 0, 1);
        seen_m2 = 0;
        run("m2_t1", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) run("m2_stall", 0, 1, 0, 0);
        run("m2_t2", 0, 0, 0, 0);
        run("m2_t3", 0, 0, 0, 0);
        run("m2_t4", 0, 0, 0, 0);
        compare("m2_length", {8'h00, 8'(seen_m2)}, 16'd7);
        finish_instr("stall_end", 0, 0);

        // Nine M-cycles without fetch: wrap from M8 and sticky overrun.
        for (int i = 0; i < 36; i++) run("overrun", 0, 0, 0, 0);
        compare("overrun_set", {15'h0, overrun}, 16'h1);
        finish_instr("overrun_end", 0, 0);
        for (int i = 0; i < 4; i++) run("overrun_sticky", 1, 0, 0, 0);

        // HALT entry, fetch ignored, wake from clock 10 with a stalled T4.
        finish_instr("halt_entry", 1, 0);
        for (int i = 1; i < 10; i++) run("halted", $urandom_range(0, 1), 0, 0, 0);
        begin
            bit stalled_once = 0;
            for (int i = 0; i < 20 && mh; i++) begin
                if (mt == 3 && !stalled_once) begin
                    stalled_once = 1;
                    run("wake_stall", 1, 1, 0, 1);
                end else begin
                    run("wake", 1, 0, 0, 1);
                end
            end
        end
        compare("woke", {15'h0, halted}, 16'h0);
        run("after_wake", 0, 0, 0, 0);

        // Halt request and wake together at the boundary: HALT not entered.
        finish_instr("req_and_wake", 1, 1);
        run("no_halt", 0, 0, 0, 0);

        // Asynchronous reset mid-instruction at M3/T3 with overrun set.
        mo = 1;
        for (int i = 0; i < 36; i++) run("overrun2", 0, 0, 0, 0);
        finish_instr("to_m1", 0, 0);
        run_to("to_m3t3", 2, 2);
        async_reset("reset_m3t3");
        for (int i = 0; i < 4; i++) run("post_reset", 1, 0, 0, 0);

        // Asynchronous reset while halted.
        finish_instr("halt_again", 1, 0);
        for (int i = 0; i < 5; i++) run("halted2", 0, 0, 0, 0);
        async_reset("reset_halt");
        for (int i = 0; i < 4; i++) run("post_reset2", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Generates the one-hot T-state (step) and M-cycle (count) vectors that every instruction microcode block decodes.
- Advances the T-state ring every clock and the M-cycle shift register at each T4.
- Returns to M1 when the active microcode signals IR fetch. Holds on bus stall. Implements HALT entry/exit at instruction boundaries.
- Sits in the ControlUnit between the decoder/microcode OR-tree and all microcode modules.

Parameters:
- N_TSTATE, 4, number of T-states per M-cycle (width of o_Cycle_Step)
- N_MCYCLE, 8, maximum M-cycles per instruction (width of o_Cycle_Count)

Ports:
- i_Clk  input  1  system clock
- i_Reset_n  input  1  asynchronous active-low reset
- i_IR_Fetch  input  1  OR of all microcode o_IR_Fetch; high during final M-cycle of instruction
- i_Stall  input  1  hold current T-state/M-cycle (bus/DMA contention)
- i_Halt_Req  input  1  HALT decoded; sampled at instruction boundary
- i_Wake  input  1  interrupt pending (IE & IF nonzero)
- o_Cycle_Step  output  N_TSTATE  one-hot T-state, bit0 = T1
- o_Cycle_Count  output  N_MCYCLE  one-hot M-cycle, bit0 = M1
- o_Instr_Start  output  1  high during M1/T1 when not halted
- o_Boundary  output  1  high during T4 of a cycle with i_IR_Fetch=1 and i_Stall=0
- o_Halted  output  1  CPU in HALT state
- o_Overrun  output  1  sticky: M-cycle count exceeded N_MCYCLE

Behaviour:
- Reset (async, i_Reset_n=0) forces these values:
  - o_Cycle_Step = 4'b0001, o_Cycle_Count = 8'b0000_0001
  - o_Halted = 0, o_Overrun = 0
  - o_Instr_Start = 1 (decoded from state)
- Release is synchronous to the next rising i_Clk.
- Step ring:
  - Rotates left one bit per clock, T4 to T1 wrap.
  - Frozen while i_Stall=1 (sampled every clock).
  - Also frozen in HALT? No: it keeps rotating in HALT.
- Count, updated only on the clock edge leaving T4 with i_Stall=0:
  - If i_IR_Fetch=1: count becomes M1. This is the instruction boundary.
  - Else if count = M(N_MCYCLE): count wraps to M1 and o_Overrun sets (cleared only by reset).
  - Else: count shifts left one bit.
- Both vectors always one-hot; no all-zero state is reachable.
- o_Boundary = step[T4] & i_IR_Fetch & ~i_Stall & ~o_Halted (combinational).
- State machine, two states: RUN and HALT.
  - RUN to HALT: at a boundary with i_Halt_Req=1 and i_Wake=0. Count goes to M1 and o_Halted=1 from the next clock.
  - HALT behaviour: count frozen at M1. Step keeps rotating. o_Instr_Start=0. o_Boundary=0. i_IR_Fetch is ignored.
  - HALT to RUN: on the edge leaving T4 with i_Wake=1. o_Halted clears; the next cycle is M1/T1 with o_Instr_Start=1.
  - i_Halt_Req and i_Wake both 1 at a boundary: HALT is not entered (no halt, no bug emulation); next cycle is M1.
  - i_Stall in HALT freezes the step ring; wake is only taken at an unstalled T4.
- o_Instr_Start = step[T1] & count[M1] & ~o_Halted (combinational).
- Reset asserted mid-instruction or mid-HALT: immediate return to reset values; no partial state retained.
- i_IR_Fetch, i_Halt_Req and i_Wake are don't-care at T1..T3.

Optional Feature:
- Macro: CYCLE_SEQUENCER_SINGLE_STEP_EN.
- When defined:
  - Adds ports i_Dbg_Hold (1, input) and i_Dbg_Step (1, input, one-clock pulse).
  - While i_Dbg_Hold=1, the sequencer freezes at the next boundary in M1/T1 and asserts o_Halted.
  - Each i_Dbg_Step pulse releases exactly one instruction, which re-freezes at its boundary.
  - i_Wake has no effect while frozen by debug.
- When undefined: ports absent; behaviour as above.

Test Plan:
- Reset release, i_IR_Fetch tied 1 -> step cycles 0001,0010,0100,1000; count stays 0000_0001; o_Instr_Start high every 4th clock.
- i_IR_Fetch high only while count=0000_0100 -> count sequence M1,M2,M3,M1; o_Boundary pulses once at M3/T4.
- i_Stall=1 for 3 clocks at M2/T2 -> step/count hold 0010/0000_0010 for 3 extra clocks; total M2 length 7 clocks.
- i_IR_Fetch held 0 for 9 M-cycles -> count wraps 1000_0000 to 0000_0001; o_Overrun=1 and stays 1 until reset.
- i_Halt_Req=1 at boundary, i_Wake=0; then i_Wake=1 at clock 10 -> o_Halted=1 from next clock; count fixed 0000_0001; exit at the first unstalled T4 at or after clock 10; the following clock is M1/T1 with o_Instr_Start=1.
- Drop i_Reset_n at M3/T3 -> outputs return immediately to 0001/0000_0001, o_Halted=0, o_Overrun=0, without a clock edge.
